conv_sched: RTL and testbench

- Layer-level scheduler that drives the single-window convolution engine through every (kernel, input-channel) job of one conv layer.
- Presents slice indices used by upstream muxes to select img/weight/bias for the engine.
- Pulses the engine's conv_en and tracks its level-type conv_fin through busy→idle.
- Emits a per-job result-valid handshake downstream and reports layer done or error.

---
 rtl/conv_sched_if.sv | 33 +++
 rtl/conv_sched.sv | 148 ++++++++++++++
 tb/tb_conv_sched.sv | 532 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_sched_if.sv
// Handshake bundle between the layer scheduler, the convolution engine and the
// downstream result consumer. The master side is the scheduler.
`timescale 1ns/1ps
interface conv_sched_if #(
    parameter int IDX_W = 4
);
    logic             start;
    logic             abort;
    logic             conv_en;
    logic             conv_fin;
    logic [IDX_W-1:0] ch_idx;
    logic [IDX_W-1:0] ker_idx;
    logic             rlt_valid;
    logic             rlt_ready;
    logic [IDX_W-1:0] rlt_ch;
    logic [IDX_W-1:0] rlt_ker;
    logic             rlt_last;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        input  start, abort, conv_fin, rlt_ready,
        output conv_en, ch_idx, ker_idx, rlt_valid, rlt_ch, rlt_ker, rlt_last,
               busy, done, err
    );

    modport slave (
        output start, abort, conv_fin, rlt_ready,
        input  conv_en, ch_idx, ker_idx, rlt_valid, rlt_ch, rlt_ker, rlt_last,
               busy, done, err
    );
endinterface

// File: rtl/conv_sched.sv
// Layer scheduler: walks every (kernel, channel) job of one conv layer through the
// single-window engine, offers each result downstream and guards engine waits with a watchdog.
`timescale 1ns/1ps
module conv_sched #(
    parameter int NUM_CH  = 3,
    parameter int NUM_KER = 2,
    parameter int IDX_W   = 4,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic         clk_en,
    input  logic         rst_n,
    conv_sched_if.master sched
);
    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_FIN, S_EMIT, S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] CH_LAST   = IDX_W'(NUM_CH - 1);
    localparam logic [IDX_W-1:0] KER_LAST  = IDX_W'(NUM_KER - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_ch;
    logic [IDX_W-1:0] r_ker;
    logic [CNT_W-1:0] r_wdog;
    logic             r_err;

    logic w_last;
    logic w_xfer;
    logic w_waiting;
    logic w_expire;
    logic w_accept;

    assign w_last    = (r_ch == CH_LAST) && (r_ker == KER_LAST);
    assign w_xfer    = (r_state == S_EMIT) && sched.rlt_ready;
    assign w_waiting = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_FIN);
    // Expire on the edge where the counter would reach TIMEOUT.
    assign w_expire  = w_waiting && (r_wdog == WDOG_LAST);
    assign w_accept  = (r_state == S_IDLE) && sched.start && !sched.abort;

    always_ff @(posedge clk_en or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (sched.abort) begin
            w_state_next = S_IDLE;
        end else if (w_expire) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:      if (sched.start) w_state_next = S_LAUNCH;
                S_LAUNCH:    w_state_next = S_WAIT_BUSY;
                // conv_fin=1 here is only the engine's status lag, never completion.
                S_WAIT_BUSY: if (!sched.conv_fin) w_state_next = S_WAIT_FIN;
                S_WAIT_FIN:  if (sched.conv_fin) w_state_next = S_EMIT;
                S_EMIT:      if (sched.rlt_ready) w_state_next = w_last ? S_DONE : S_LAUNCH;
                S_DONE:      w_state_next = S_IDLE;
                default:     w_state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        sched.conv_en   = 1'b0;
        sched.busy      = 1'b0;
        sched.rlt_valid = 1'b0;
        sched.rlt_last  = 1'b0;
        sched.done      = 1'b0;
        case (r_state)
            S_LAUNCH: begin
                sched.conv_en = 1'b1;
                sched.busy    = 1'b1;
            end
            S_WAIT_BUSY: begin
                sched.conv_en = sched.conv_fin;
                sched.busy    = 1'b1;
            end
            S_WAIT_FIN: begin
                sched.busy = 1'b1;
            end
            S_EMIT: begin
                sched.busy      = 1'b1;
                sched.rlt_valid = 1'b1;
                sched.rlt_last  = w_last;
            end
            S_DONE: begin
                sched.done = 1'b1;
            end
            default: begin
                sched.busy = 1'b0;
            end
        endcase
    end

    // Indices move only on start or an accepted result, keeping engine inputs stable per job.
    always_ff @(posedge clk_en or negedge rst_n) begin
        if (!rst_n) begin
            r_ch  <= '0;
            r_ker <= '0;
        end else if (w_accept) begin
            r_ch  <= '0;
            r_ker <= '0;
        end else if (w_xfer && !sched.abort && !w_last) begin
            if (r_ch == CH_LAST) begin
                r_ch  <= '0;
                r_ker <= r_ker + IDX_ONE;
            end else begin
                r_ch <= r_ch + IDX_ONE;
            end
        end
    end

    always_ff @(posedge clk_en or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= '0;
        end else if (r_state == S_LAUNCH) begin
            r_wdog <= '0;
        end else if (w_waiting) begin
            r_wdog <= r_wdog + CNT_ONE;
        end
    end

    always_ff @(posedge clk_en or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (w_expire && !sched.abort) begin
            r_err <= 1'b1;
        end
    end

    assign sched.ch_idx  = r_ch;
    assign sched.ker_idx = r_ker;
    assign sched.rlt_ch  = r_ch;
    assign sched.rlt_ker = r_ker;
    assign sched.err     = r_err;
endmodule

// File: tb/tb_conv_sched.sv
// Bench for conv_sched: engine models with status lag, a job-order reference built from
// nested loops, and one task per scenario on a 3x2 layer plus a 1x1 layer instance.
`timescale 1ns/1ps
module tb_conv_sched;
    localparam int NCH  = 3;
    localparam int NKER = 2;
    localparam int IW   = 4;
    localparam int TO   = 64;

    typedef struct packed {
        logic [IW-1:0] ch;
        logic [IW-1:0] ker;
        logic          last;
    } xfer_t;

    logic clk_en = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clk_en = ~clk_en;

    conv_sched_if #(.IDX_W(IW)) ifc ();
    conv_sched_if #(.IDX_W(IW)) ifc1 ();

    conv_sched #(.NUM_CH(NCH), .NUM_KER(NKER), .IDX_W(IW), .TIMEOUT(TO), .CNT_W(8)) dut (
        .clk_en(clk_en), .rst_n(rst_n), .sched(ifc)
    );
    conv_sched #(.NUM_CH(1), .NUM_KER(1), .IDX_W(IW), .TIMEOUT(TO), .CNT_W(8)) dut1 (
        .clk_en(clk_en), .rst_n(rst_n), .sched(ifc1)
    );

    int n_checks = 0;
    int n_bad    = 0;

    // Engine models: conv_fin stays high 2 cycles after accepting conv_en, then low for the job length.
    int eng_t   = 0;
    int eng_len = 5;
    int eng1_t  = 0;
    bit eng_hang = 1'b0;
    bit eng_rand = 1'b0;

    always @(posedge clk_en or negedge rst_n) begin
        if (!rst_n) begin
            eng_t <= 0;
        end else if (eng_t == 0) begin
            if (ifc.conv_en && !eng_hang) begin
                eng_t   <= 1;
                eng_len <= eng_rand ? int'($urandom_range(1, 8)) : 5;
            end
        end else if (eng_t >= 2 + eng_len) begin
            eng_t <= 0;
        end else begin
            eng_t <= eng_t + 1;
        end
    end
    assign ifc.conv_fin = (eng_t < 3);

    always @(posedge clk_en or negedge rst_n) begin
        if (!rst_n) begin
            eng1_t <= 0;
        end else if (eng1_t == 0) begin
            if (ifc1.conv_en) eng1_t <= 1;
        end else if (eng1_t >= 7) begin
            eng1_t <= 0;
        end else begin
            eng1_t <= eng1_t + 1;
        end
    end
    assign ifc1.conv_fin = (eng1_t < 3);

    // Mid-cycle monitor of transfers, conv_en cycles per job and done pulses.
    xfer_t obs_q[$];
    int    en_q[$];
    int    cur_en = 0;
    int    cyc = 0;
    int    last_xfer_cyc = 0;
    int    done_cnt = 0;
    int    done_cyc = 0;
    int    x1_cnt = 0;
    xfer_t x1_val;
    int    x1_cyc = 0;
    int    d1_cnt = 0;
    int    d1_cyc = 0;

    always @(negedge clk_en) begin
        if (!rst_n) begin
            cur_en <= 0;
        end else begin
            cyc <= cyc + 1;
            if (ifc.rlt_valid && ifc.rlt_ready) begin
                obs_q.push_back({ifc.rlt_ch, ifc.rlt_ker, ifc.rlt_last});
                en_q.push_back(cur_en);
                cur_en        <= 0;
                last_xfer_cyc <= cyc;
            end else if (ifc.conv_en) begin
                cur_en <= cur_en + 1;
            end
            if (ifc.done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (ifc1.rlt_valid && ifc1.rlt_ready) begin
                x1_cnt <= x1_cnt + 1;
                x1_val <= {ifc1.rlt_ch, ifc1.rlt_ker, ifc1.rlt_last};
                x1_cyc <= cyc;
            end
            if (ifc1.done) begin
                d1_cnt <= d1_cnt + 1;
                d1_cyc <= cyc;
            end
        end
    end

    // Reference job order: kernels outer, channels inner, last flag only on the final pair.
    xfer_t exp_q[$];
    function automatic void build_exp(input int nch, input int nker);
        exp_q.delete();
        for (int k = 0; k < nker; k++)
            for (int c = 0; c < nch; c++)
                exp_q.push_back({IW'(c), IW'(k), (c == nch - 1) && (k == nker - 1)});
    endfunction

    task automatic step();
        @(posedge clk_en);
        #1;
    endtask

    task automatic pulse_start();
        ifc.start = 1'b1;
        step();
        ifc.start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            step();
            if (done_cnt > d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #23;
        n_checks++;
        if ({ifc.busy, ifc.done, ifc.err, ifc.conv_en, ifc.rlt_valid, ifc.rlt_last} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 000000",
                     {ifc.busy, ifc.done, ifc.err, ifc.conv_en, ifc.rlt_valid, ifc.rlt_last});
        end
        n_checks++;
        if ({ifc.ch_idx, ifc.ker_idx, ifc.rlt_ch, ifc.rlt_ker} !== '0) begin
            n_bad++;
            $display("FAIL reset_idx: got ch=%0d ker=%0d rch=%0d rker=%0d want 0",
                     ifc.ch_idx, ifc.ker_idx, ifc.rlt_ch, ifc.rlt_ker);
        end
        #5 rst_n = 1'b1;
        step();
        step();
        n_checks++;
        if ({ifc.busy, ifc.conv_en, ifc.done} !== 3'b0) begin
            n_bad++;
            $display("FAIL post_reset_idle: got %b want 000", {ifc.busy, ifc.conv_en, ifc.done});
        end
    endtask

    task automatic test_nominal();
        int n0, e0, d0;
        bit ok;
        build_exp(NCH, NKER);
        n0 = obs_q.size();
        e0 = en_q.size();
        d0 = done_cnt;
        ifc.rlt_ready = 1'b1;
        eng_rand = 1'b0;
        pulse_start();
        wait_done(d0, 400, ok);
        n_checks++;
        if (!ok) begin
            n_bad++;
            $display("FAIL nominal_done_timeout: got no done want done");
        end
        for (int k = 0; k < 4; k++) step();
        n_checks++;
        if (obs_q.size() - n0 !== exp_q.size()) begin
            n_bad++;
            $display("FAIL nominal_count: got %0d want %0d", obs_q.size() - n0, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && n0 + i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[n0+i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL nominal_job%0d: got ch=%0d ker=%0d last=%0b want ch=%0d ker=%0d last=%0b",
                         i, obs_q[n0+i].ch, obs_q[n0+i].ker, obs_q[n0+i].last,
                         exp_q[i].ch, exp_q[i].ker, exp_q[i].last);
            end
            n_checks++;
            if (en_q[e0+i] !== 3) begin
                n_bad++;
                $display("FAIL nominal_conv_en_len%0d: got %0d want 3", i, en_q[e0+i]);
            end
        end
        n_checks++;
        if (done_cnt - d0 !== 1) begin
            n_bad++;
            $display("FAIL nominal_done_count: got %0d want 1", done_cnt - d0);
        end
        n_checks++;
        if (done_cyc - last_xfer_cyc !== 1) begin
            n_bad++;
            $display("FAIL nominal_done_delay: got %0d want 1", done_cyc - last_xfer_cyc);
        end
        $display("nominal: %0d jobs, done_cnt=%0d", obs_q.size() - n0, done_cnt);
    endtask

    task automatic test_random_bp();
        int n0, d0;
        bit ok;
        build_exp(NCH, NKER);
        eng_rand = 1'b1;
        for (int run = 0; run < 3; run++) begin
            n0 = obs_q.size();
            d0 = done_cnt;
            pulse_start();
            ok = 1'b0;
            for (int k = 0; k < 2000 && !ok; k++) begin
                ifc.rlt_ready = 1'($urandom_range(0, 1));
                step();
                ok = (done_cnt > d0);
            end
            ifc.rlt_ready = 1'b1;
            n_checks++;
            if (!ok) begin
                n_bad++;
                $display("FAIL rand_done_timeout run%0d: got no done want done", run);
            end
            n_checks++;
            if (obs_q.size() - n0 !== exp_q.size()) begin
                n_bad++;
                $display("FAIL rand_count run%0d: got %0d want %0d", run, obs_q.size() - n0, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && n0 + i < obs_q.size(); i++) begin
                n_checks++;
                if (obs_q[n0+i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL rand_job run%0d idx%0d: got ch=%0d ker=%0d last=%0b want ch=%0d ker=%0d last=%0b",
                             run, i, obs_q[n0+i].ch, obs_q[n0+i].ker, obs_q[n0+i].last,
                             exp_q[i].ch, exp_q[i].ker, exp_q[i].last);
                end
            end
            $display("random_bp run%0d: %0d jobs", run, obs_q.size() - n0);
            for (int k = 0; k < 3; k++) step();
        end
        eng_rand = 1'b0;
    endtask

    task automatic test_backpressure();
        int n0, d0, bad_cyc;
        bit ok;
        n0 = obs_q.size();
        d0 = done_cnt;
        ifc.rlt_ready = 1'b1;
        pulse_start();
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            ok = (obs_q.size() > n0);
            if (!ok) step();
        end
        ifc.rlt_ready = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            step();
            ok = (ifc.rlt_valid === 1'b1);
        end
        n_checks++;
        if (!ok) begin
            n_bad++;
            $display("FAIL bp_reach_emit: got no rlt_valid want rlt_valid");
        end
        bad_cyc = 0;
        for (int k = 0; k < 10; k++) begin
            if ({ifc.rlt_valid, ifc.rlt_ch, ifc.rlt_ker, ifc.conv_en, ifc.ch_idx, ifc.ker_idx}
                !== {1'b1, IW'(1), IW'(0), 1'b0, IW'(1), IW'(0)}) bad_cyc++;
            step();
        end
        n_checks++;
        if (bad_cyc !== 0) begin
            n_bad++;
            $display("FAIL bp_hold: got %0d unstable cycles want 0", bad_cyc);
        end
        n_checks++;
        if (obs_q.size() - n0 !== 1) begin
            n_bad++;
            $display("FAIL bp_no_xfer: got %0d transfers want 1", obs_q.size() - n0);
        end
        ifc.rlt_ready = 1'b1;
        wait_done(d0, 400, ok);
        n_checks++;
        if (!ok || obs_q.size() - n0 !== NCH * NKER) begin
            n_bad++;
            $display("FAIL bp_finish: got done=%0b xfers=%0d want done=1 xfers=%0d",
                     ok, obs_q.size() - n0, NCH * NKER);
        end
        $display("backpressure: held 10 cycles, %0d jobs", obs_q.size() - n0);
        for (int k = 0; k < 3; k++) step();
    endtask

    task automatic test_timeout();
        int d0;
        d0 = done_cnt;
        eng_hang = 1'b1;
        pulse_start();
        for (int k = 0; k < 63; k++) step();
        n_checks++;
        if ({ifc.err, ifc.busy} !== 2'b01) begin
            n_bad++;
            $display("FAIL timeout_early: got err=%0b busy=%0b want err=0 busy=1", ifc.err, ifc.busy);
        end
        step();
        step();
        n_checks++;
        if ({ifc.err, ifc.busy, ifc.conv_en} !== 3'b100) begin
            n_bad++;
            $display("FAIL timeout_err: got err=%0b busy=%0b conv_en=%0b want 1 0 0",
                     ifc.err, ifc.busy, ifc.conv_en);
        end
        for (int k = 0; k < 5; k++) step();
        n_checks++;
        if (ifc.err !== 1'b1 || done_cnt !== d0) begin
            n_bad++;
            $display("FAIL timeout_sticky: got err=%0b dones=%0d want err=1 dones=0", ifc.err, done_cnt - d0);
        end
        pulse_start();
        n_checks++;
        if ({ifc.err, ifc.busy} !== 2'b01) begin
            n_bad++;
            $display("FAIL timeout_clear: got err=%0b busy=%0b want err=0 busy=1", ifc.err, ifc.busy);
        end
        ifc.abort = 1'b1;
        step();
        ifc.abort = 1'b0;
        eng_hang = 1'b0;
        step();
        $display("timeout: err raised and cleared");
    endtask

    task automatic test_abort();
        int n0, d0, n1;
        bit ok;
        n0 = obs_q.size();
        d0 = done_cnt;
        ifc.rlt_ready = 1'b1;
        pulse_start();
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            step();
            ok = (obs_q.size() - n0 >= NCH) && ifc.busy && !ifc.conv_en && !ifc.rlt_valid
                 && !ifc.conv_fin && (ifc.ker_idx == IW'(1));
        end
        step();
        n_checks++;
        if (!ok || ifc.conv_fin !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_reach_wait: got ok=%0b fin=%0b want ok=1 fin=0", ok, ifc.conv_fin);
        end
        ifc.abort = 1'b1;
        step();
        ifc.abort = 1'b0;
        n_checks++;
        if ({ifc.busy, ifc.conv_en, ifc.rlt_valid} !== 3'b000) begin
            n_bad++;
            $display("FAIL abort_idle: got busy=%0b conv_en=%0b valid=%0b want 0 0 0",
                     ifc.busy, ifc.conv_en, ifc.rlt_valid);
        end
        for (int k = 0; k < 12; k++) step();
        n_checks++;
        if (done_cnt !== d0 || ifc.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_no_done: got dones=%0d busy=%0b want 0 0", done_cnt - d0, ifc.busy);
        end
        n1 = obs_q.size();
        pulse_start();
        n_checks++;
        if ({ifc.busy, ifc.ch_idx, ifc.ker_idx} !== {1'b1, IW'(0), IW'(0)}) begin
            n_bad++;
            $display("FAIL abort_restart: got busy=%0b ch=%0d ker=%0d want 1 0 0",
                     ifc.busy, ifc.ch_idx, ifc.ker_idx);
        end
        wait_done(d0, 400, ok);
        n_checks++;
        if (!ok || obs_q.size() - n1 !== NCH * NKER) begin
            n_bad++;
            $display("FAIL abort_rerun: got done=%0b xfers=%0d want 1 %0d", ok, obs_q.size() - n1, NCH * NKER);
        end
        $display("abort: restarted layer ran %0d jobs", obs_q.size() - n1);
        for (int k = 0; k < 3; k++) step();
    endtask

    task automatic test_start_edges();
        int n0, d0;
        bit ok;
        n0 = obs_q.size();
        d0 = done_cnt;
        ifc.rlt_ready = 1'b1;
        pulse_start();
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            step();
            ok = (obs_q.size() > n0) && ifc.busy;
        end
        pulse_start();
        n_checks++;
        if ({ifc.busy, ifc.ch_idx, ifc.ker_idx} !== {1'b1, IW'(1), IW'(0)}) begin
            n_bad++;
            $display("FAIL start_while_busy: got busy=%0b ch=%0d ker=%0d want 1 1 0",
                     ifc.busy, ifc.ch_idx, ifc.ker_idx);
        end
        wait_done(d0, 400, ok);
        for (int k = 0; k < 3; k++) step();
        n_checks++;
        if (!ok || obs_q.size() - n0 !== NCH * NKER || done_cnt - d0 !== 1) begin
            n_bad++;
            $display("FAIL start_while_busy_run: got xfers=%0d dones=%0d want %0d 1",
                     obs_q.size() - n0, done_cnt - d0, NCH * NKER);
        end
        ifc.start = 1'b1;
        ifc.abort = 1'b1;
        step();
        ifc.start = 1'b0;
        ifc.abort = 1'b0;
        n_checks++;
        if ({ifc.busy, ifc.conv_en} !== 2'b00) begin
            n_bad++;
            $display("FAIL start_abort_idle: got busy=%0b conv_en=%0b want 0 0", ifc.busy, ifc.conv_en);
        end
        step();
        n_checks++;
        if (ifc.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL start_abort_stay: got busy=%0b want 0", ifc.busy);
        end
        $display("start_edges: busy start ignored, start+abort stayed idle");
    endtask

    task automatic test_single();
        int x0, d0;
        bit ok;
        x0 = x1_cnt;
        d0 = d1_cnt;
        ifc1.start = 1'b1;
        step();
        ifc1.start = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            step();
            ok = (d1_cnt > d0);
        end
        step();
        n_checks++;
        if (!ok || x1_cnt - x0 !== 1) begin
            n_bad++;
            $display("FAIL single_count: got done=%0b xfers=%0d want 1 1", ok, x1_cnt - x0);
        end
        n_checks++;
        if (x1_val !== {IW'(0), IW'(0), 1'b1}) begin
            n_bad++;
            $display("FAIL single_fields: got ch=%0d ker=%0d last=%0b want 0 0 1",
                     x1_val.ch, x1_val.ker, x1_val.last);
        end
        n_checks++;
        if (d1_cyc - x1_cyc !== 1 || ifc1.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_done: got delay=%0d busy=%0b want 1 0", d1_cyc - x1_cyc, ifc1.busy);
        end
        $display("single: 1x1 layer, xfers=%0d", x1_cnt - x0);
    endtask

    task automatic test_async_reset();
        bit ok;
        ifc.rlt_ready = 1'b0;
        pulse_start();
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            step();
            ok = (ifc.rlt_valid === 1'b1);
        end
        n_checks++;
        if (!ok || ifc.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL areset_reach_emit: got valid=%0b busy=%0b want 1 1", ifc.rlt_valid, ifc.busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ifc.busy, ifc.rlt_valid, ifc.rlt_last, ifc.conv_en, ifc.done, ifc.err,
             ifc.ch_idx, ifc.ker_idx, ifc.rlt_ch, ifc.rlt_ker} !== '0) begin
            n_bad++;
            $display("FAIL areset_immediate: got busy=%0b valid=%0b ch=%0d ker=%0d want all 0",
                     ifc.busy, ifc.rlt_valid, ifc.ch_idx, ifc.ker_idx);
        end
        #2 rst_n = 1'b1;
        ifc.rlt_ready = 1'b1;
        step();
        n_checks++;
        if ({ifc.busy, ifc.rlt_valid, ifc.conv_en} !== 3'b000) begin
            n_bad++;
            $display("FAIL areset_after: got busy=%0b valid=%0b conv_en=%0b want 0 0 0",
                     ifc.busy, ifc.rlt_valid, ifc.conv_en);
        end
        $display("async_reset: outputs cleared before next edge");
    endtask

    initial begin
        ifc.start      = 1'b0;
        ifc.abort      = 1'b0;
        ifc.rlt_ready  = 1'b0;
        ifc1.start     = 1'b0;
        ifc1.abort     = 1'b0;
        ifc1.rlt_ready = 1'b1;
        test_reset();
        test_nominal();
        test_random_bp();
        test_backpressure();
        test_timeout();
        test_abort();
        test_start_edges();
        test_single();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
